vd_pattern_gen: RTL

VD_PATTERN_GEN -- requirements
Module: vd_pattern_gen

---
 rtl/vd_pkg.sv | 21 ++
 rtl/vd_timing.sv | 84 ++++++++
 rtl/vd_pattern_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/vd_pkg.sv
// Shared definitions for the VD test-pattern generator: pattern modes and default
// raster timing (341 dots x 262 lines).
package vd_pkg;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    BARS     = 2'd1,
    CHECKER  = 2'd2,
    GRADIENT = 2'd3
  } vd_mode_e;

  localparam int VD_H_TOTAL  = 341;
  localparam int VD_H_SYNC   = 32;
  localparam int VD_H_START  = 64;
  localparam int VD_H_ACTIVE = 256;
  localparam int VD_V_TOTAL  = 262;
  localparam int VD_V_SYNC   = 3;
  localparam int VD_V_START  = 14;
  localparam int VD_V_ACTIVE = 240;

endpackage

// File: rtl/vd_timing.sv
// Raster counters for the VD pattern generator: dot/line position, frame counter
// and combinational sync/active decode. VD_SCROLL_EN exports the frame counter.
module vd_timing
  import vd_pkg::*;
#(
  parameter int H_TOTAL  = VD_H_TOTAL,
  parameter int H_SYNC   = VD_H_SYNC,
  parameter int H_START  = VD_H_START,
  parameter int H_ACTIVE = VD_H_ACTIVE,
  parameter int V_TOTAL  = VD_V_TOTAL,
  parameter int V_SYNC   = VD_V_SYNC,
  parameter int V_START  = VD_V_START,
  parameter int V_ACTIVE = VD_V_ACTIVE,
  parameter int HW       = $clog2(H_TOTAL),
  parameter int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic [HW-1:0] hcount_o,
  output logic [VW-1:0] vcount_o,
`ifdef VD_SCROLL_EN
  output logic [7:0]    frame_cnt_o,
`endif
  output logic          origin_o,
  output logic          hsync_low_o,
  output logic          vsync_low_o,
  output logic          active_o
);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [31:0]   h32, v32;
  logic          h_last, v_last;

  assign h32    = 32'(hcount_q);
  assign v32    = 32'(vcount_q);
  assign h_last = (h32 == 32'(H_TOTAL - 1));
  assign v_last = (v32 == 32'(V_TOTAL - 1));

  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;
    if (en_i) begin
      if (h_last) begin
        hcount_d = '0;
        if (v_last) begin
          vcount_d    = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          vcount_d = vcount_q + VW'(1);
        end
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      frame_cnt_q <= 8'd0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hcount_o    = hcount_q;
  assign vcount_o    = vcount_q;
`ifdef VD_SCROLL_EN
  assign frame_cnt_o = frame_cnt_q;
`endif
  assign origin_o    = (hcount_q == '0) && (vcount_q == '0);
  assign hsync_low_o = (h32 < 32'(H_SYNC));
  assign vsync_low_o = (v32 < 32'(V_SYNC));
  assign active_o    = (h32 >= 32'(H_START)) && (h32 < 32'(H_START + H_ACTIVE)) &&
                       (v32 >= 32'(V_START)) && (v32 < 32'(V_START + V_ACTIVE));

endmodule

// File: rtl/vd_pattern_gen.sv
// VD test-pattern source for the VCE pixel bus: four selectable patterns, registered
// outputs one cycle behind the raster position. VD_SCROLL_EN scrolls bars/checker per frame.
module vd_pattern_gen
  import vd_pkg::*;
#(
  parameter int H_TOTAL  = VD_H_TOTAL,
  parameter int H_SYNC   = VD_H_SYNC,
  parameter int H_START  = VD_H_START,
  parameter int H_ACTIVE = VD_H_ACTIVE,
  parameter int V_TOTAL  = VD_V_TOTAL,
  parameter int V_SYNC   = VD_V_SYNC,
  parameter int V_START  = VD_V_START,
  parameter int V_ACTIVE = VD_V_ACTIVE
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [7:0] color,
  output logic [8:0] VD,
  output logic       HSYNC_n,
  output logic       VSYNC_n,
  output logic       frame_start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          origin, hsync_low, vsync_low, active;
  logic [3:0]    x_hi;
  logic [7:0]    y;
  vd_mode_e      frame_mode_q, frame_mode_d;
  logic [8:0]    vd_q, vd_d;
  logic          hsync_n_q, vsync_n_q, frame_start_q;
`ifdef VD_SCROLL_EN
  logic [7:0]    frame_cnt;
`endif

  vd_timing #(
    .H_TOTAL (H_TOTAL), .H_SYNC (H_SYNC), .H_START (H_START), .H_ACTIVE (H_ACTIVE),
    .V_TOTAL (V_TOTAL), .V_SYNC (V_SYNC), .V_START (V_START), .V_ACTIVE (V_ACTIVE),
    .HW (HW), .VW (VW)
  ) u_timing (
    .clk_i       (clock),
    .rst_ni      (reset_N),
    .en_i        (en),
    .hcount_o    (hcount),
    .vcount_o    (vcount),
`ifdef VD_SCROLL_EN
    .frame_cnt_o (frame_cnt),
`endif
    .origin_o    (origin),
    .hsync_low_o (hsync_low),
    .vsync_low_o (vsync_low),
    .active_o    (active)
  );

  // Only x[7:4] is ever consumed, so take it straight from the offset (mod 256).
`ifdef VD_SCROLL_EN
  assign x_hi = 4'((32'(hcount) - 32'(H_START) + 32'(frame_cnt)) >> 4);
`else
  assign x_hi = 4'((32'(hcount) - 32'(H_START)) >> 4);
`endif
  assign y = 8'(32'(vcount) - 32'(V_START));

  always_comb begin
    frame_mode_d = origin ? vd_mode_e'(mode) : frame_mode_q;
    vd_d         = 9'h000;
    if (active) begin
      case (frame_mode_q)
        SOLID:   vd_d = {1'b0, color};
        BARS:    vd_d = {5'h00, x_hi};
        CHECKER: vd_d = {x_hi[0] ^ y[4], color};
        default: vd_d = {1'b0, y};
      endcase
    end
  end

  // frame_start is cleared on a stalled clock so the pulse never stretches.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      frame_mode_q  <= SOLID;
      vd_q          <= 9'h000;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= en & origin;
      if (en) begin
        frame_mode_q <= frame_mode_d;
        vd_q         <= vd_d;
        hsync_n_q    <= ~hsync_low;
        vsync_n_q    <= ~vsync_low;
      end
    end
  end

  assign VD          = vd_q;
  assign HSYNC_n     = hsync_n_q;
  assign VSYNC_n     = vsync_n_q;
  assign frame_start = frame_start_q;

endmodule
